// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use stall, branch flush and ALU operand forwarding control for a 5-stage RV32I pipeline
module hazard_forward_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_en,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             flush_if_id,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rw;
    logic       mr;
  } ex_t;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
  } tag_t;
  ex_t              ex_d, ex_q;
  tag_t             mem_d, mem_q, wb_d, wb_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic             raw_stall;
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic ex_v, input tag_t mem, input tag_t wb);
    return !ex_v ? 2'd0 :
           (mem.v && mem.rw && mem.rd != 5'd0 && mem.rd == rs) ? 2'd1 :
           (wb.v && wb.rw && wb.rd != 5'd0 && wb.rd == rs) ? 2'd2 : 2'd0;
  endfunction
  always_comb begin
    fwd_a_sel = fwd(ex_q.rs1, ex_q.v, mem_q, wb_q);
    fwd_b_sel = fwd(ex_q.rs2, ex_q.v, mem_q, wb_q);
    raw_stall = ex_q.v && ex_q.mr && ex_q.rd != 5'd0 && id_valid &&
                ((id_uses_rs1 && id_rs1 == ex_q.rd) || (id_uses_rs2 && id_rs2 == ex_q.rd));
    flush_if_id = ex_branch_taken && ex_q.v;
    stall = raw_stall && !flush_if_id;
    pc_write = !stall;
    if_id_write = !stall;
    id_ex_bubble = stall || flush_if_id;
    ex_d = !pipe_en ? ex_q : id_ex_bubble ? ex_t'('0) :
           ex_t'({id_valid, id_rd, id_rs1, id_rs2, id_reg_write, id_mem_read});
    mem_d = pipe_en ? tag_t'({ex_q.v, ex_q.rd, ex_q.rw}) : mem_q;
    wb_d = pipe_en ? mem_q : wb_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(pipe_en && stall && !(&stall_cnt_q));
    flush_cnt_d = flush_cnt_q + CNT_W'(pipe_en && flush_if_id && !(&flush_cnt_q));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed and randomized checks of hazard_forward_ctrl against a stage-list reference model
module tb_hazard_forward_ctrl;
  localparam int CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst, pipe_en, id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic stall, pc_write, if_id_write, flush_if_id, id_ex_bubble;
  logic [CNT_W-1:0] stall_count, flush_count;
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    bit v;
    int rd;
    int rs1;
    int rs2;
    bit rw;
    bit mr;
  } instr_t;
  instr_t m[3];
  int m_stall_cnt, m_flush_cnt;
  always #5 clk = ~clk;
  hazard_forward_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write), .flush_if_id(flush_if_id),
    .id_ex_bubble(id_ex_bubble), .stall_count(stall_count), .flush_count(flush_count)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int exp_sel(int r);
    if (!m[0].v) return 0;
    for (int s = 1; s < 3; s++)
      if (m[s].v && m[s].rw && m[s].rd != 0 && m[s].rd == r) return s;
    return 0;
  endfunction
  function automatic bit exp_flush();
    return ex_branch_taken && m[0].v;
  endfunction
  function automatic bit exp_stall();
    bit hit;
    hit = m[0].v && m[0].mr && m[0].rd != 0 && id_valid &&
          ((id_uses_rs1 && int'(id_rs1) == m[0].rd) || (id_uses_rs2 && int'(id_rs2) == m[0].rd));
    return hit && !exp_flush();
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask
  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit br);
    id_valid = v;
    id_rs1 = 5'(rs1);
    id_rs2 = 5'(rs2);
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_rd = 5'(rd);
    id_reg_write = rw;
    id_mem_read = mr;
    ex_branch_taken = br;
  endtask
  task automatic check_all(input string p);
    check({p, "fwd_a"}, 32'(fwd_a_sel), 32'(exp_sel(int'(dut_rs(1)))));
    check({p, "fwd_b"}, 32'(fwd_b_sel), 32'(exp_sel(int'(dut_rs(2)))));
    check({p, "stall"}, 32'(stall), 32'(exp_stall()));
    check({p, "pc_write"}, 32'(pc_write), 32'(!exp_stall()));
    check({p, "if_id_write"}, 32'(if_id_write), 32'(!exp_stall()));
    check({p, "flush"}, 32'(flush_if_id), 32'(exp_flush()));
    check({p, "bubble"}, 32'(id_ex_bubble), 32'(exp_stall() || exp_flush()));
    check({p, "stall_count"}, 32'(stall_count), 32'(m_stall_cnt));
    check({p, "flush_count"}, 32'(flush_count), 32'(m_flush_cnt));
  endtask
  function automatic int dut_rs(int which);
    return which == 1 ? m[0].rs1 : m[0].rs2;
  endfunction
  task automatic cyc();
    bit s, f;
    @(negedge clk);
    check_all("cyc_");
    @(posedge clk);
    if (pipe_en) begin
      s = exp_stall();
      f = exp_flush();
      if (s && m_stall_cnt < MAXC) m_stall_cnt++;
      if (f && m_flush_cnt < MAXC) m_flush_cnt++;
      m[2] = m[1];
      m[1] = m[0];
      if (s || f) m[0] = '{default: 0};
      else m[0] = '{v: id_valid, rd: int'(id_rd), rs1: int'(id_rs1), rs2: int'(id_rs2),
                     rw: id_reg_write, mr: id_mem_read};
    end
    #1;
  endtask
  initial begin
    rst = 1'b1;
    pipe_en = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_all("reset_");
    check("reset_pc_write", 32'(pc_write), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc();
    drive(1, 5, 6, 1, 1, 8, 1, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    check("dist1_a", 32'(fwd_a_sel), 32'd0);
    drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc();
    drive(1, 5, 6, 1, 1, 8, 1, 0, 0);
    cyc();
    check("dist1_fwd_a", 32'(fwd_a_sel), 32'd1);
    check("dist1_fwd_b", 32'(fwd_b_sel), 32'd0);
    drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc();
    drive(1, 3, 4, 1, 1, 5, 1, 0, 0);
    cyc();
    drive(1, 9, 5, 1, 1, 10, 1, 0, 0);
    cyc();
    check("double_hit_fwd_b", 32'(fwd_b_sel), 32'd1);
    check("double_hit_fwd_a", 32'(fwd_a_sel), 32'd0);
    drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc();
    drive(1, 1, 2, 1, 1, 5, 0, 0, 0);
    cyc();
    drive(1, 9, 5, 1, 1, 10, 1, 0, 0);
    cyc();
    check("wb_only_fwd_b", 32'(fwd_b_sel), 32'd2);
    drive(1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc();
    drive(1, 7, 2, 1, 1, 11, 1, 0, 0);
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_pc_write", 32'(pc_write), 32'd0);
    check("lu_if_id_write", 32'(if_id_write), 32'd0);
    check("lu_bubble", 32'(id_ex_bubble), 32'd1);
    cyc();
    #1;
    check("lu_one_cycle", 32'(stall), 32'd0);
    check("lu_stall_count", 32'(stall_count), 32'd1);
    cyc();
    check("lu_fwd_wb", 32'(fwd_a_sel), 32'd2);
    drive(1, 1, 0, 1, 0, 0, 1, 1, 0);
    cyc();
    drive(1, 0, 2, 1, 1, 12, 1, 0, 0);
    #1;
    check("x0_load_no_stall", 32'(stall), 32'd0);
    cyc();
    drive(1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc();
    drive(1, 3, 7, 1, 0, 12, 1, 0, 0);
    #1;
    check("unused_rs2_no_stall", 32'(stall), 32'd0);
    cyc();
    drive(1, 1, 2, 1, 1, 0, 1, 0, 0);
    cyc();
    drive(1, 0, 0, 1, 1, 12, 1, 0, 0);
    cyc();
    check("x0_fwd_a", 32'(fwd_a_sel), 32'd0);
    check("x0_fwd_b", 32'(fwd_b_sel), 32'd0);
    drive(1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc();
    drive(1, 7, 2, 1, 1, 11, 1, 0, 1);
    #1;
    check("br_flush", 32'(flush_if_id), 32'd1);
    check("br_no_stall", 32'(stall), 32'd0);
    check("br_bubble", 32'(id_ex_bubble), 32'd1);
    cyc();
    #1;
    check("br_flush_count", 32'(flush_count), 32'd1);
    check("br_ex_invalid", 32'(flush_if_id), 32'd0);
    drive(1, 1, 2, 1, 1, 5, 1, 0, 0);
    cyc();
    drive(1, 5, 2, 1, 1, 13, 1, 0, 0);
    cyc();
    pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom_range(0, 31), $urandom_range(0, 31), 1, 1, $urandom_range(0, 31), 1, 1, 0);
      cyc();
      check("freeze_fwd_a", 32'(fwd_a_sel), 32'd1);
      check("freeze_stall_count", 32'(stall_count), 32'd1);
      check("freeze_flush_count", 32'(flush_count), 32'd1);
    end
    pipe_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 1, 0, 7, 1, 1, 0);
      cyc();
      drive(1, 7, 2, 1, 1, 11, 1, 0, 0);
      cyc();
      cyc();
      drive(1, 1, 2, 1, 1, 14, 0, 0, 0);
      cyc();
      ex_branch_taken = 1'b1;
      cyc();
    end
    check("sat_stall_count", 32'(stall_count), 32'(MAXC));
    check("sat_flush_count", 32'(flush_count), 32'(MAXC));
    drive(1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc();
    drive(1, 7, 2, 1, 1, 11, 1, 0, 0);
    #1;
    check("rst_pre_stall", 32'(stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_stall", 32'(stall), 32'd0);
    check("rst_async_bubble", 32'(id_ex_bubble), 32'd0);
    check("rst_async_pc_write", 32'(pc_write), 32'd1);
    check("rst_async_fwd_a", 32'(fwd_a_sel), 32'd0);
    check("rst_async_fwd_b", 32'(fwd_b_sel), 32'd0);
    check("rst_async_flush", 32'(flush_if_id), 32'd0);
    check("rst_async_stall_count", 32'(stall_count), 32'd0);
    check("rst_async_flush_count", 32'(flush_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      pipe_en = $urandom_range(0, 7) != 0;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
